// File: rtl/reqwalker_multi_if.sv
// Wishbone pipelined slave bus for the LED request walker, plus the LED outputs.
interface reqwalker_multi_if #(
  parameter int NLEDS = 8
);
  logic              i_cyc;
  logic              i_stb;
  logic              i_we;
  logic [1:0]        i_addr;
  logic [31:0]       i_data;
  logic              o_stall;
  logic              o_ack;
  logic [31:0]       o_data;
  logic [NLEDS-1:0]  o_led;

  modport slave (
    input  i_cyc, i_stb, i_we, i_addr, i_data,
    output o_stall, o_ack, o_data, o_led
  );

  modport master (
    output i_cyc, i_stb, i_we, i_addr, i_data,
    input  o_stall, o_ack, o_data, o_led
  );
endinterface

// File: rtl/reqwalker_multi.sv
// Wishbone slave that walks a single lit LED forward, in reverse or bouncing,
// with a step prescaler, repeat count, abort and completed-walk counter.
//   state  | meaning
//   S_IDLE | no walk in progress, o_led = 0, CTRL writes start a walk
//   S_WALK | LED walking; CTRL/PRE writes ignored, ABORT returns to idle
module reqwalker_multi #(
  parameter int          NLEDS            = 8,
  parameter int          PRESCALE_W       = 16,
  parameter int unsigned DEFAULT_PRESCALE = 0,
  parameter int          REPEAT_W         = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  reqwalker_multi_if.slave    bus
);
  localparam int              PW   = (NLEDS > 2) ? $clog2(NLEDS) : 1;
  localparam logic [PW-1:0]   LAST = PW'(NLEDS - 1);
  localparam logic [NLEDS-1:0] ONE = NLEDS'(1);

  typedef enum logic {S_IDLE, S_WALK} state_t;

  state_t                state_q;
  logic [1:0]            mode_q;
  logic                  dir_q;
  logic [PW-1:0]         pos_q;
  logic [REPEAT_W-1:0]   rep_q;
  logic [PRESCALE_W-1:0] timer_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic [31:0]           done_q;
  logic                  ack_q;
  logic [31:0]           data_q;
  logic [NLEDS-1:0]      led_q;

  logic                  req, wr, busy, is_rev, is_bnc, w_rev;
  logic                  pass_end;
  logic [PW-1:0]         pos_d, restart_pos;
  logic                  dir_d;
  logic [31:0]           rdata_d;
  logic                  unused_data;

  assign req         = bus.i_cyc & bus.i_stb;
  assign wr          = req & bus.i_we;
  assign busy        = (state_q == S_WALK);
  assign is_rev      = (mode_q == 2'd2);
  assign is_bnc      = (mode_q == 2'd1);
  assign w_rev       = (bus.i_data[1:0] == 2'd2);
  assign restart_pos = is_rev ? LAST : '0;
  assign unused_data = ^bus.i_data;

  // dir=1 always heads toward 0, which is where reverse and bounce passes end
  always_comb begin
    pass_end = 1'b0;
    pos_d    = pos_q;
    dir_d    = dir_q;
    if (dir_q) begin
      if (pos_q == '0) pass_end = 1'b1;
      else             pos_d = pos_q - 1'b1;
    end else if (pos_q == LAST) begin
      if (is_bnc) begin
        dir_d = 1'b1;
        pos_d = pos_q - 1'b1;
      end else begin
        pass_end = 1'b1;
      end
    end else begin
      pos_d = pos_q + 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (bus.i_addr)
      2'd0: begin
        rdata_d[31]    = busy;
        rdata_d[30]    = dir_q;
        rdata_d[25:24] = mode_q;
        rdata_d[23:16] = 8'(rep_q);
        rdata_d[7:0]   = 8'(pos_q);
      end
      2'd1:    rdata_d = 32'(pre_q);
      2'd2:    rdata_d = done_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      rep_q   <= '0;
      timer_q <= '0;
      pre_q   <= PRESCALE_W'(DEFAULT_PRESCALE);
      done_q  <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      led_q   <= '0;
    end else begin
      ack_q  <= req;
      data_q <= (req && !bus.i_we) ? rdata_d : '0;
      if (wr && bus.i_addr == 2'd1 && !busy) pre_q <= bus.i_data[PRESCALE_W-1:0];
      if (wr && bus.i_addr == 2'd3) begin
        state_q <= S_IDLE;
        led_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (wr && bus.i_addr == 2'd0) begin
              state_q <= S_WALK;
              mode_q  <= bus.i_data[1:0];
              rep_q   <= bus.i_data[8 +: REPEAT_W];
              dir_q   <= w_rev;
              pos_q   <= w_rev ? LAST : '0;
              led_q   <= ONE << (w_rev ? LAST : '0);
              timer_q <= pre_q;
            end
          end
          S_WALK: begin
            if (timer_q != '0) begin
              timer_q <= timer_q - 1'b1;
            end else begin
              timer_q <= pre_q;
              if (!pass_end) begin
                pos_q <= pos_d;
                dir_q <= dir_d;
                led_q <= ONE << pos_d;
              end else if (rep_q != '0) begin
                rep_q <= rep_q - 1'b1;
                pos_q <= restart_pos;
                dir_q <= is_rev;
                led_q <= ONE << restart_pos;
              end else begin
                state_q <= S_IDLE;
                led_q   <= '0;
                done_q  <= done_q + 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_stall = 1'b0;
  assign bus.o_ack   = ack_q;
  assign bus.o_data  = data_q;
  assign bus.o_led   = led_q;
endmodule

// File: tb/tb_reqwalker_multi.sv
// Scoreboard bench for reqwalker_multi: bus responses are queued at issue time
// and checked by an independent ack monitor; LED patterns are checked per cycle.
module tb_reqwalker_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  reqwalker_multi_if #(.NLEDS(8)) bus ();

  reqwalker_multi #(
    .NLEDS(8), .PRESCALE_W(16), .DEFAULT_PRESCALE(0), .REPEAT_W(8)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    if (bus.o_ack === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack data=%h required=no ack", bus.o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.o_data !== e.data) begin
          n_bad++;
          $display("FAIL %s got=%h required=%h", e.name, bus.o_data, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", nm, got, want);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string nm);
    exp_t x;
    x.name = nm;
    x.data = we ? 32'h0 : e;
    bus.i_cyc  = 1'b1;
    bus.i_stb  = 1'b1;
    bus.i_we   = we;
    bus.i_addr = a;
    bus.i_data = d;
    exp_q.push_back(x);
    @(negedge clk);
    bus.i_cyc = 1'b0;
    bus.i_stb = 1'b0;
    bus.i_we  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string nm);
    issue(1'b1, a, d, 32'h0, nm);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    issue(1'b0, a, 32'h0, e, nm);
  endtask

  logic [2:0] bnc_pos[$];

  initial begin
    bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(bus.o_led), 32'h0);
    chk("reset_ack", 32'(bus.o_ack), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, 32'h0, "reset_pre");
    rd(2'd2, 32'h0, "reset_done");
    rd(2'd0, 32'h0, "reset_ctrl");

    // forward walk, one LED per cycle
    wr(2'd1, 32'h0, "wr_pre0");
    wr(2'd0, 32'h0, "wr_ctrl_fwd");
    for (int i = 0; i < 8; i++) begin
      chk("fwd_led", 32'(bus.o_led), 32'h1 << i);
      @(negedge clk);
    end
    chk("fwd_led_end", 32'(bus.o_led), 32'h0);
    rd(2'd2, 32'd1, "done_after_fwd");

    // bounce, prescale 2, one repeat: 15 positions per pass, two passes
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) bnc_pos.push_back(3'(i));
      for (int i = 6; i >= 0; i--) bnc_pos.push_back(3'(i));
    end
    wr(2'd1, 32'd2, "wr_pre2");
    wr(2'd0, 32'h101, "wr_ctrl_bounce");
    for (int k = 0; k < 90; k++) begin
      chk("bounce_led", 32'(bus.o_led), 32'h1 << bnc_pos[k / 3]);
      if (k == 40) rd(2'd0, 32'hC101_0001, "bounce_ctrl_mid");
      else         @(negedge clk);
    end
    chk("bounce_led_end", 32'(bus.o_led), 32'h0);
    rd(2'd2, 32'd2, "done_after_bounce");

    // busy writes ignored, then abort mid-walk
    wr(2'd1, 32'd3, "wr_pre3");
    wr(2'd0, 32'h0, "wr_ctrl_fwd2");
    wr(2'd0, 32'h2, "wr_ctrl_busy");
    wr(2'd1, 32'd7, "wr_pre_busy");
    rd(2'd0, 32'h8000_0000, "ctrl_busy_read");
    chk("busy_led_unchanged", 32'(bus.o_led), 32'h01);
    wr(2'd3, 32'h0, "wr_abort");
    chk("abort_led", 32'(bus.o_led), 32'h0);

    // back-to-back reads of all four registers
    rd(2'd0, 32'h0, "b2b_ctrl");
    rd(2'd1, 32'd3, "b2b_pre");
    rd(2'd2, 32'd2, "b2b_done");
    rd(2'd3, 32'h0, "b2b_abort");

    // strobe without cycle is not a request
    bus.i_stb = 1'b1;
    @(negedge clk);
    bus.i_stb = 1'b0;
    chk("stb_no_cyc_ack", 32'(bus.o_ack), 32'h0);

    // reverse walk
    wr(2'd1, 32'h0, "wr_pre0b");
    wr(2'd0, 32'h2, "wr_ctrl_rev");
    for (int i = 0; i < 8; i++) begin
      chk("rev_led", 32'(bus.o_led), 32'h80 >> i);
      @(negedge clk);
    end
    chk("rev_led_end", 32'(bus.o_led), 32'h0);
    rd(2'd2, 32'd3, "done_after_rev");

    // DONE wrap, mode 3 behaves as forward
    force dut.done_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.done_q;
    rd(2'd2, 32'hFFFF_FFFF, "done_preload");
    wr(2'd0, 32'h3, "wr_ctrl_mode3");
    for (int i = 0; i < 8; i++) begin
      chk("mode3_led", 32'(bus.o_led), 32'h1 << i);
      @(negedge clk);
    end
    rd(2'd2, 32'h0, "done_wrap");

    // asynchronous reset mid-walk with an ack outstanding
    wr(2'd1, 32'd5, "wr_pre5");
    wr(2'd0, 32'h0, "wr_ctrl_fwd3");
    repeat (2) @(negedge clk);
    rd(2'd2, 32'h0, "done_before_reset");
    chk("led_before_reset", 32'(bus.o_led), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_led", 32'(bus.o_led), 32'h0);
    chk("reset_mid_ack", 32'(bus.o_ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, 32'h0, "pre_after_reset");
    rd(2'd2, 32'h0, "done_after_reset");
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
